// File: rtl/usb_phy_pkg.sv
// Shared USB PHY definitions used by both the NRZI transmit and receive paths.
// Holds the unstuffer FSM encoding, the bit-stuff run length and line levels.
package usb_phy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam int   USB_STUFF_LEN = 6;
  localparam logic USB_J_LEVEL   = 1'b1;
  localparam logic USB_K_LEVEL   = 1'b0;

endpackage

// File: rtl/bit_unstuffer.sv
// Drops stuffed bits from the decoded NRZ stream, flags stuff violations and SE0.
// Owns the run-length counter and the IDLE/RUN/ERR FSM; all outputs registered, 1-cycle latency.
module bit_unstuffer
  import usb_phy_pkg::*;
#(
  parameter int STUFF_LEN = USB_STUFF_LEN
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_dec,
  input  logic i_valid,
  input  logic i_se0,
  output logic o_data,
  output logic o_valid,
  output logic o_stuff_err,
  output logic o_eop,
  output logic o_active
);

  localparam int CNT_W = $clog2(STUFF_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STUFF_LEN);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_ones_cnt;
  logic [CNT_W-1:0] w_ones_cnt_nxt;
  logic             r_data, w_data_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_stuff_err, w_stuff_err_nxt;
  logic             r_eop, w_eop_nxt;
  logic             r_active;
  logic             w_stuff_slot;

  assign w_stuff_slot = (r_ones_cnt == CNT_MAX);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_ones_cnt  <= '0;
      r_data      <= 1'b0;
      r_valid     <= 1'b0;
      r_stuff_err <= 1'b0;
      r_eop       <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ones_cnt  <= w_ones_cnt_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_stuff_err <= w_stuff_err_nxt;
      r_eop       <= w_eop_nxt;
      r_active    <= (w_state_nxt == ST_RUN);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_valid) begin
      if (i_se0) begin
        w_state_nxt = ST_IDLE;
      end else begin
        unique case (r_state)
          ST_IDLE, ST_RUN: w_state_nxt = (w_stuff_slot && i_dec) ? ST_ERR : ST_RUN;
          ST_ERR:          w_state_nxt = ST_ERR;
          default:         w_state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  // IDLE decodes its first bit exactly like RUN so the packet's first bit is not lost.
  always_comb begin
    w_ones_cnt_nxt  = r_ones_cnt;
    w_data_nxt      = r_data;
    w_valid_nxt     = 1'b0;
    w_stuff_err_nxt = 1'b0;
    w_eop_nxt       = 1'b0;
    if (i_valid) begin
      if (i_se0) begin
        w_eop_nxt      = 1'b1;
        w_ones_cnt_nxt = '0;
      end else if (r_state != ST_ERR) begin
        if (!w_stuff_slot) begin
          w_data_nxt     = i_dec;
          w_valid_nxt    = 1'b1;
          w_ones_cnt_nxt = i_dec ? (r_ones_cnt + CNT_W'(1)) : '0;
        end else begin
          w_stuff_err_nxt = i_dec;
          w_ones_cnt_nxt  = '0;
        end
      end
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_stuff_err = r_stuff_err;
  assign o_eop       = r_eop;
  assign o_active    = r_active;

endmodule

// File: rtl/nrzi_decoder.sv
// USB receive NRZI decoder: tracks the previous line level and XNOR-decodes to NRZ,
// then hands the decoded bit to the unstuffer. One-cycle registered latency, no backpressure.
module nrzi_decoder
  import usb_phy_pkg::*;
#(
  parameter logic IDLE_LEVEL = USB_J_LEVEL,
  parameter int   STUFF_LEN  = USB_STUFF_LEN
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_data,
  input  logic i_valid,
  input  logic i_se0,
  output logic o_data,
  output logic o_valid,
  output logic o_stuff_err,
  output logic o_eop,
  output logic o_active
);

  logic r_prev_line;
  logic w_dec;

  assign w_dec = ~(i_data ^ r_prev_line);

  // Line history keeps tracking in ERR so a later packet decodes correctly; SE0 restores J.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev_line <= IDLE_LEVEL;
    end else if (i_valid) begin
      r_prev_line <= i_se0 ? IDLE_LEVEL : i_data;
    end
  end

  bit_unstuffer #(
    .STUFF_LEN (STUFF_LEN)
  ) u_unstuffer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_dec       (w_dec),
    .i_valid     (i_valid),
    .i_se0       (i_se0),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_stuff_err (o_stuff_err),
    .o_eop       (o_eop),
    .o_active    (o_active)
  );

endmodule

// File: tb/tb_nrzi_decoder.sv
// Self-checking bench for nrzi_decoder: directed vector table plus random traffic
// compared against a packet-level reference model.
module tb_nrzi_decoder;

  localparam int STUFF = 6;

  logic i_clk = 1'b0;
  logic i_rst, i_data, i_valid, i_se0;
  logic o_data, o_valid, o_stuff_err, o_eop, o_active;

  int n_vec = 0;
  int n_bad = 0;

  nrzi_decoder dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .i_se0       (i_se0),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_stuff_err (o_stuff_err),
    .o_eop       (o_eop),
    .o_active    (o_active)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic rst, vld, dat, se0;
    logic ev, ed, eerr, eeop, eact;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, vld, dat, se0, ev, ed, eerr, eeop, eact);
    vec_t v;
    v.rst = rst; v.vld = vld; v.dat = dat; v.se0 = se0;
    v.ev = ev; v.ed = ed; v.eerr = eerr; v.eeop = eeop; v.eact = eact;
    vecs.push_back(v);
  endfunction

  // Line bit that is delivered as a decoded bit d (active afterwards).
  function automatic void bit_ok(input logic line, input logic d);
    add(0, 1, line, 0, 1, d, 0, 0, 1);
  endfunction

  function automatic void eop();
    add(0, 1, 0, 1, 0, 0, 0, 1, 0);
  endfunction

  task automatic drive_and_clock(input logic rst, vld, dat, se0);
    i_rst = rst; i_valid = vld; i_data = dat; i_se0 = se0;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b (vector %0d)", name, act, exp, n_vec);
    end
  endtask

  // Reference model: packet state kept as a list of counted decoded bits.
  logic m_prev, m_err, m_act, m_data, m_vld, m_serr, m_eop;
  logic m_run[$];

  function automatic int trailing_ones();
    int n = 0;
    for (int k = m_run.size() - 1; k >= 0 && m_run[k] == 1'b1 && n < STUFF; k--) n++;
    return n;
  endfunction

  function automatic void model(input logic rst, vld, dat, se0);
    logic dec;
    m_vld = 0; m_serr = 0; m_eop = 0;
    if (rst) begin
      m_prev = 1; m_err = 0; m_act = 0; m_data = 0; m_run.delete();
    end else if (vld && se0) begin
      m_eop = 1; m_prev = 1; m_err = 0; m_act = 0; m_run.delete();
    end else if (vld) begin
      dec = (dat == m_prev);
      m_prev = dat;
      if (!m_err) begin
        if (trailing_ones() == STUFF) begin
          m_run.delete();
          if (dec) begin
            m_serr = 1; m_err = 1; m_act = 0;
          end else begin
            m_act = 1;
          end
        end else begin
          m_run.push_back(dec);
          m_data = dec; m_vld = 1; m_act = 1;
        end
      end
    end
  endfunction

  initial begin
    logic line;
    logic rst, vld, se0;

    // 1: reset then first bit
    add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    bit_ok(1, 1);
    eop();
    // 2: basic decode, then same with gaps
    bit_ok(1, 1); bit_ok(0, 0); bit_ok(0, 1); bit_ok(1, 0); bit_ok(1, 1);
    eop();
    bit_ok(1, 1); add(0, 0, 0, 0, 0, 0, 0, 0, 1);
    bit_ok(0, 0); add(0, 0, 1, 0, 0, 0, 0, 0, 1);
    bit_ok(0, 1); add(0, 0, 0, 1, 0, 0, 0, 0, 1);
    bit_ok(1, 0); add(0, 0, 0, 0, 0, 0, 0, 0, 1);
    bit_ok(1, 1);
    eop();
    // 3: unstuffing
    for (int k = 0; k < 6; k++) bit_ok(1, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0, 1);
    bit_ok(0, 1);
    for (int k = 0; k < 5; k++) bit_ok(0, 1);
    add(0, 1, 1, 0, 0, 0, 0, 0, 1);
    eop();
    // 4: stuff error, ERR swallows bits until SE0
    for (int k = 0; k < 6; k++) bit_ok(1, 1);
    add(0, 1, 1, 0, 0, 0, 1, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0);
    eop();
    // 5: SE0 on the stuff slot, then decode against restored J
    for (int k = 0; k < 6; k++) bit_ok(1, 1);
    eop();
    bit_ok(0, 0);
    eop();
    // 6: reset mid-packet clears the run counter
    for (int k = 0; k < 4; k++) bit_ok(1, 1);
    add(1, 1, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) bit_ok(1, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0, 1);
    bit_ok(0, 1);
    eop();

    foreach (vecs[i]) begin
      drive_and_clock(vecs[i].rst, vecs[i].vld, vecs[i].dat, vecs[i].se0);
      n_vec++;
      chk("tbl_valid", o_valid, vecs[i].ev);
      if (vecs[i].ev || vecs[i].rst) chk("tbl_data", o_data, vecs[i].ed);
      chk("tbl_stuff_err", o_stuff_err, vecs[i].eerr);
      chk("tbl_eop", o_eop, vecs[i].eeop);
      chk("tbl_active", o_active, vecs[i].eact);
    end

    // Random traffic against the model, starting from a reset.
    line = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      rst = (c == 0) || ($urandom_range(0, 149) == 0);
      vld = ($urandom_range(0, 3) != 0);
      se0 = vld && ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) line = ~line;
      model(rst, vld, line, se0);
      drive_and_clock(rst, vld, line, se0);
      n_vec++;
      chk("rnd_valid", o_valid, m_vld);
      chk("rnd_data", o_data, m_data);
      chk("rnd_stuff_err", o_stuff_err, m_serr);
      chk("rnd_eop", o_eop, m_eop);
      chk("rnd_active", o_active, m_act);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
